// File: rtl/stamp_capture_pkg.sv
// stamp_capture_pkg: shared defaults, channel encoding and the stamp-entry layout
// for the PTP time stamp capture block. A channel tag is {dir, port}; dir=1 is tx.
package stamp_capture_pkg;

   localparam int DEF_NUM_QUEUES  = 8;
   localparam int DEF_STAMP_WIDTH = 64;
   localparam int DEF_FIFO_DEPTH  = 8;

   localparam int CHAN_WIDTH = $clog2(DEF_NUM_QUEUES);

   localparam logic DIR_RX = 1'b0;
   localparam logic DIR_TX = 1'b1;

   // One queued stamp: channel tag above the captured time.
   typedef struct packed {
      logic [CHAN_WIDTH-1:0]      chan;
      logic [DEF_STAMP_WIDTH-1:0] stamp;
   } stamp_entry_t;

   localparam int ENTRY_WIDTH = CHAN_WIDTH + DEF_STAMP_WIDTH;

   // Direction of a channel index: the upper half of the channels are tx strobes.
   function automatic logic chan_dir(input int chan, input int num_queues);
      return (chan >= num_queues / 2) ? DIR_TX : DIR_RX;
   endfunction

endpackage

// File: rtl/stamp_fifo.sv
// stamp_fifo: parameterised first-word-fall-through FIFO. The head entry is
// visible on pop_data whenever empty=0. A push while full is accepted only if a
// pop happens in the same cycle, leaving the occupancy unchanged.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module stamp_fifo
   import stamp_capture_pkg::*;
#(
   parameter int WIDTH = ENTRY_WIDTH,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW + 1)'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/stamp_capture.sv
// stamp_capture: latches the nanosecond counter on rising edges of the per-port
// rx/tx start-of-frame strobes, holds one stamp per channel, and round-robins
// the held stamps into a FWFT output FIFO tagged with {dir, port}.
// Build option: define STAMP_CAPTURE_LATENCY_COMP_EN to subtract RX_LATENCY_NS
// from rx stamps and add TX_LATENCY_NS to tx stamps at capture time.
//
// Output handshake: stamp_valid means the head entry on stamp_data/stamp_chan is
// present; the entry is consumed in any cycle where stamp_valid and stamp_ready
// are both high, and the next entry (if any) is shown the following cycle.
module stamp_capture
   import stamp_capture_pkg::*;
#(
   parameter int                     NUM_QUEUES    = DEF_NUM_QUEUES,
   parameter int                     STAMP_WIDTH   = DEF_STAMP_WIDTH,
   parameter int                     FIFO_DEPTH    = DEF_FIFO_DEPTH,
   parameter logic [STAMP_WIDTH-1:0] RX_LATENCY_NS = '0,
   parameter logic [STAMP_WIDTH-1:0] TX_LATENCY_NS = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [STAMP_WIDTH-1:0]        counter_val,
   input  logic [NUM_QUEUES/2-1:0]       valid_rx,
   input  logic [NUM_QUEUES/2-1:0]       valid_tx,
   output logic                          stamp_valid,
   input  logic                          stamp_ready,
   output logic [STAMP_WIDTH-1:0]        stamp_data,
   output logic [$clog2(NUM_QUEUES)-1:0] stamp_chan,
   output logic [NUM_QUEUES-1:0]         overflow,
   input  logic                          overflow_clr
);

   localparam int CW = $clog2(NUM_QUEUES);
   localparam int EW = CW + STAMP_WIDTH;

   // Edge detection: rx ports occupy channels 0..N/2-1, tx ports the upper half.
   logic [NUM_QUEUES-1:0]  strobe;
   logic [NUM_QUEUES-1:0]  strobe_d1;
   logic [NUM_QUEUES-1:0]  event_vec;

   // Stage 1 holding registers, one per channel.
   logic [STAMP_WIDTH-1:0] cap_val   [NUM_QUEUES];
   logic [STAMP_WIDTH-1:0] hold_data [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]  hold_full;
   logic [NUM_QUEUES-1:0]  overrun_vec;

   // Stage 2 arbiter.
   logic [CW-1:0]          ptr;
   logic [CW-1:0]          cand;
   logic [CW-1:0]          grant_idx;
   logic                   grant_any;
   logic [NUM_QUEUES-1:0]  grant_vec;

   // Output FIFO.
   logic [EW-1:0]          push_data;
   logic [EW-1:0]          head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;

   assign strobe    = {valid_tx, valid_rx};
   assign event_vec = strobe & ~strobe_d1;

   // Value written into a holding register when its channel sees an edge.
`ifdef STAMP_CAPTURE_LATENCY_COMP_EN
   always_comb begin
      for (int c = 0; c < NUM_QUEUES; c++) begin
         if (chan_dir(c, NUM_QUEUES) == DIR_TX) begin
            cap_val[c] = counter_val + TX_LATENCY_NS;
         end else begin
            cap_val[c] = counter_val - RX_LATENCY_NS;
         end
      end
   end
`else
   logic unused_latency;
   assign unused_latency = ^{RX_LATENCY_NS, TX_LATENCY_NS};

   always_comb begin
      for (int c = 0; c < NUM_QUEUES; c++) begin
         cap_val[c] = counter_val;
      end
   end
`endif

   // Round-robin search starting at ptr; no grant while the FIFO is full.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         cand = CW'((int'(ptr) + i) % NUM_QUEUES);
         if (!grant_any && hold_full[cand] && !fifo_full) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign grant_vec   = grant_any ? (NUM_QUEUES'(1) << grant_idx) : '0;
   // A drain in the same cycle frees the register, so only an undrained full register overruns.
   assign overrun_vec = event_vec & hold_full & ~grant_vec;
   assign push_data   = {grant_idx, hold_data[grant_idx]};

   // Edge history, holding registers, sticky overflow flags and the arbiter pointer.
   // During reset the edge history follows the strobes, so a level held across
   // reset is not mistaken for a new start-of-frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         strobe_d1 <= strobe;
         hold_full <= '0;
         overflow  <= '0;
         ptr       <= '0;
         for (int c = 0; c < NUM_QUEUES; c++) begin
            hold_data[c] <= '0;
         end
      end else begin
         strobe_d1 <= strobe;
         for (int c = 0; c < NUM_QUEUES; c++) begin
            if (event_vec[c]) begin
               hold_data[c] <= cap_val[c];
            end
         end
         hold_full <= (hold_full & ~grant_vec) | event_vec;
         overflow  <= (overflow & ~{NUM_QUEUES{overflow_clr}}) | overrun_vec;
         if (grant_any) begin
            ptr <= CW'((int'(grant_idx) + 1) % NUM_QUEUES);
         end
      end
   end

   assign pop = ~fifo_empty & stamp_ready;

   stamp_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (grant_any),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign stamp_valid = ~fifo_empty;
   assign stamp_chan  = head[EW-1 -: CW];
   assign stamp_data  = head[STAMP_WIDTH-1:0];

endmodule

// File: tb/tb_stamp_capture.sv
// tb_stamp_capture: directed scenarios followed by randomized traffic, each cycle
// checked against a transaction-level model of the capture/arbitration/FIFO rules.
module tb_stamp_capture;
   import stamp_capture_pkg::*;

   localparam int NQ    = 8;
   localparam int SW    = 64;
   localparam int DEPTH = 8;
   localparam logic [SW-1:0] RX_LAT = 64'h20;
   localparam logic [SW-1:0] TX_LAT = 64'h10;

   // ---------------- clock / reset / DUT ----------------
   logic            clk;
   logic            reset;
   logic [SW-1:0]   counter_val;
   logic [NQ/2-1:0] valid_rx;
   logic [NQ/2-1:0] valid_tx;
   logic            stamp_valid;
   logic            stamp_ready;
   logic [SW-1:0]   stamp_data;
   logic [2:0]      stamp_chan;
   logic [NQ-1:0]   overflow;
   logic            overflow_clr;

   initial clk = 1'b0;
   always #4 clk = ~clk;

   stamp_capture #(
      .NUM_QUEUES    (NQ),
      .STAMP_WIDTH   (SW),
      .FIFO_DEPTH    (DEPTH),
      .RX_LATENCY_NS (RX_LAT),
      .TX_LATENCY_NS (TX_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .counter_val  (counter_val),
      .valid_rx     (valid_rx),
      .valid_tx     (valid_tx),
      .stamp_valid  (stamp_valid),
      .stamp_ready  (stamp_ready),
      .stamp_data   (stamp_data),
      .stamp_chan   (stamp_chan),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   // ---------------- scoreboard / reference model ----------------
   int tests;
   int fails;

   logic [ENTRY_WIDTH-1:0] exp_q[$];
   logic [NQ-1:0]          prev_m;
   logic [NQ-1:0]          held_m;
   logic [NQ-1:0]          ovf_m;
   logic [SW-1:0]          held_val_m [NQ];
   int                     ptr_m;

   function automatic logic [SW-1:0] exp_stamp(input int c, input logic [SW-1:0] cv);
`ifdef STAMP_CAPTURE_LATENCY_COMP_EN
      return (c >= NQ / 2) ? cv + TX_LAT : cv - RX_LAT;
`else
      return cv;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      logic [NQ-1:0] strobe;
      logic [NQ-1:0] ev;
      int            g;
      int            c;
      strobe = {valid_tx, valid_rx};
      if (reset) begin
         prev_m = strobe;
         held_m = '0;
         ovf_m  = '0;
         ptr_m  = 0;
         exp_q.delete();
      end else begin
         ev = strobe & ~prev_m;
         g  = -1;
         if (exp_q.size() < DEPTH) begin
            for (int i = 0; i < NQ; i++) begin
               c = (ptr_m + i) % NQ;
               if (g < 0 && held_m[c]) g = c;
            end
         end
         if (exp_q.size() > 0 && stamp_ready) void'(exp_q.pop_front());
         if (g >= 0) begin
            exp_q.push_back({3'(g), held_val_m[g]});
            held_m[g] = 1'b0;
            ptr_m     = (g + 1) % NQ;
         end
         if (overflow_clr) ovf_m = '0;
         for (int k = 0; k < NQ; k++) begin
            if (ev[k]) begin
               if (held_m[k]) ovf_m[k] = 1'b1;
               held_val_m[k] = exp_stamp(k, counter_val);
               held_m[k]     = 1'b1;
            end
         end
         prev_m = strobe;
      end
   endtask

   task automatic check_outputs();
      stamp_entry_t head;
      check("stamp_valid", 64'(stamp_valid), 64'(exp_q.size() > 0));
      check("overflow", 64'(overflow), 64'(ovf_m));
      if (exp_q.size() > 0) begin
         head = exp_q[0];
         check("stamp_chan", 64'(stamp_chan), 64'(head.chan));
         check("stamp_data", stamp_data, head.stamp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic set_strobes(input logic [3:0] rx, input logic [3:0] tx);
      valid_rx = rx;
      valid_tx = tx;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      counter_val  = '0;
      valid_rx     = '0;
      valid_tx     = '0;
      stamp_ready  = 1'b0;
      overflow_clr = 1'b0;
      prev_m       = '0;
      held_m       = '0;
      ovf_m        = '0;
      ptr_m        = 0;
      for (int i = 0; i < NQ; i++) held_val_m[i] = '0;

      // Reset state
      step();
      step();
      reset = 1'b0;
      check("rst_valid", 64'(stamp_valid), 64'd0);
      check("rst_data", stamp_data, 64'd0);
      check("rst_chan", 64'(stamp_chan), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);

      // All eight strobes in one cycle, consumer always ready
      counter_val = 64'h1000;
      stamp_ready = 1'b1;
      set_strobes(4'hF, 4'hF);
      step();
      set_strobes(4'h0, 4'h0);
      counter_val = 64'h1008;
      step();
      for (int i = 0; i < NQ; i++) begin
         check("all8_chan", 64'(stamp_chan), 64'(i));
         check("all8_data", stamp_data, exp_stamp(i, 64'h1000));
         counter_val = counter_val + 64'd8;
         step();
      end
      check("all8_empty", 64'(stamp_valid), 64'd0);
      check("all8_overflow", 64'(overflow), 64'd0);

      // Single rx event, two-cycle latency, then pop
      stamp_ready = 1'b0;
      counter_val = 64'h64;
      set_strobes(4'b0100, 4'h0);
      step();
      set_strobes(4'h0, 4'h0);
      counter_val = 64'h6C;
      step();
      check("single_valid", 64'(stamp_valid), 64'd1);
      check("single_chan", 64'(stamp_chan), 64'd2);
      check("single_data", stamp_data, exp_stamp(2, 64'h64));
      stamp_ready = 1'b1;
      step();
      check("single_popped", 64'(stamp_valid), 64'd0);
      stamp_ready = 1'b0;

      // Backpressure: 12 events, FIFO fills, holding registers keep the rest
      do_reset();
      for (int k = 0; k < 12; k++) begin
         counter_val = 64'h2000 + 64'(k * 8);
         if (k == 0) set_strobes(4'hF, 4'hF);
         else if (k == 4) set_strobes(4'b1100, 4'b0011);
         else set_strobes(4'h0, 4'h0);
         step();
      end
      check("bp_full_valid", 64'(stamp_valid), 64'd1);
      check("bp_overflow", 64'(overflow), 64'h30);
      stamp_ready = 1'b1;
      for (int k = 0; k < 12; k++) step();
      check("bp_drained", 64'(stamp_valid), 64'd0);
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      check("bp_ovf_clr", 64'(overflow), 64'd0);

      // Overrun on tx port 1 while the FIFO is full
      stamp_ready = 1'b0;
      set_strobes(4'hF, 4'hF);
      step();
      set_strobes(4'h0, 4'h0);
      for (int k = 0; k < 10; k++) step();
      counter_val = 64'h3000;
      set_strobes(4'h0, 4'b0010);
      step();
      set_strobes(4'h0, 4'h0);
      for (int k = 1; k < 4; k++) begin
         counter_val = 64'h3000 + 64'(k * 8);
         step();
      end
      counter_val = 64'h3020;
      set_strobes(4'h0, 4'b0010);
      step();
      set_strobes(4'h0, 4'h0);
      check("ovr_flag", 64'(overflow), 64'h20);
      stamp_ready = 1'b1;
      for (int k = 0; k < 12; k++) step();
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      check("ovr_clr", 64'(overflow), 64'd0);

      // Reset mid-drain with a strobe held high through reset
      stamp_ready = 1'b0;
      set_strobes(4'b0111, 4'h0);
      step();
      set_strobes(4'h0, 4'h0);
      for (int k = 0; k < 4; k++) step();
      check("mid_queued", 64'(stamp_valid), 64'd1);
      reset = 1'b1;
      set_strobes(4'b0001, 4'h0);
      step();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("mid_no_event", 64'(stamp_valid), 64'd0);
      end
      set_strobes(4'h0, 4'h0);
      step();

`ifdef STAMP_CAPTURE_LATENCY_COMP_EN
      // Latency compensation and wrap-around
      do_reset();
      counter_val = 64'h100;
      set_strobes(4'b0001, 4'b0001);
      step();
      set_strobes(4'h0, 4'h0);
      step();
      check("comp_rx_data", stamp_data, 64'hE0);
      stamp_ready = 1'b1;
      step();
      check("comp_tx_chan", 64'(stamp_chan), 64'd4);
      check("comp_tx_data", stamp_data, 64'h110);
      step();
      stamp_ready = 1'b0;
      counter_val = 64'h10;
      set_strobes(4'b0010, 4'h0);
      step();
      set_strobes(4'h0, 4'h0);
      step();
      check("comp_wrap", stamp_data, 64'hFFFF_FFFF_FFFF_FFF0);
      stamp_ready = 1'b1;
      step();
      stamp_ready = 1'b0;
`endif

      // Randomized traffic: heavy strobes, varying backpressure, clears and resets
      for (int n = 0; n < 600; n++) begin
         counter_val  = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) set_strobes(4'($urandom), 4'($urandom));
         if (n < 300) stamp_ready = ($urandom_range(0, 3) != 0);
         else stamp_ready = ($urandom_range(0, 3) == 0);
         overflow_clr = ($urandom_range(0, 15) == 0);
         reset        = ($urandom_range(0, 99) == 0);
         step();
      end
      reset        = 1'b0;
      overflow_clr = 1'b0;
      set_strobes(4'h0, 4'h0);
      stamp_ready  = 1'b1;
      for (int k = 0; k < 20; k++) step();
      check("final_empty", 64'(stamp_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
